// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a stallable N-to-1 registered mux.
// Locks the grant for multi-beat packets and force-releases after MAX_BEATS beats.
module mux_rr_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_BEATS = 16,
    localparam int unsigned CW       = $clog2(N),
    localparam int unsigned BW       = $clog2(MAX_BEATS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_valid,
    input  logic [N-1:0]  req_last,
    output logic [N-1:0]  req_ready,
    output logic [CW-1:0] mux_sel,
    output logic          mux_stall,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [N-1:0]  grant,
    output logic          burst_overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [CW-1:0] sel_q, sel_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          ov_q, ov_d;
    logic          ol_q, ol_d;
    logic          bo_q, bo_d;

    logic          stall;
    logic          fire;
    logic          owner_last;
    logic          win_found;
    logic [CW-1:0] win_idx;

    assign stall      = ov_q & ~out_ready;
    assign owner_last = req_last[sel_q];
    assign fire       = (state_q == BUSY) & ~stall & req_valid[sel_q];

    // First requester at or above ptr, wrapping past N-1 back to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned cand;
            cand = (32'(ptr_q) + i) % N;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = CW'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == BUSY && !stall) begin
            req_ready[sel_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        ol_d    = ol_q;
        bo_d    = 1'b0;

        if (!stall) begin
            ov_d = fire;
            ol_d = fire & owner_last;
        end

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    sel_d            = win_idx;
                    cnt_d            = '0;
                    state_d          = BUSY;
                end
            end
            BUSY: begin
                if (fire) begin
                    cnt_d = cnt_q + BW'(1);
                    if (owner_last || cnt_q == BW'(MAX_BEATS - 1)) begin
                        bo_d    = ~owner_last;
                        grant_d = '0;
                        ptr_d   = (sel_q == CW'(N - 1)) ? '0 : sel_q + CW'(1);
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
            bo_q    <= bo_d;
        end
    end

    assign mux_sel       = sel_q;
    assign mux_stall     = stall;
    assign out_valid     = ov_q;
    assign out_last      = ol_q;
    assign grant         = grant_q;
    assign burst_overrun = bo_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed cycle-by-cycle vectors for mux_rr_arbiter (N=4, MAX_BEATS=4)
// plus a hand-written asynchronous-reset sequence.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_last;
    logic [3:0] req_ready;
    logic [1:0] mux_sel;
    logic       mux_stall;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic [3:0] grant;
    logic       burst_overrun;

    int n_chk;
    int n_fail;

    mux_rr_arbiter #(.N(4), .MAX_BEATS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .mux_sel      (mux_sel),
        .mux_stall    (mux_stall),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .grant        (grant),
        .burst_overrun(burst_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rl;
        logic       ordy;
        logic [3:0] g;
        logic [1:0] sel;
        logic [3:0] rdy;
        logic       stall;
        logic       ov;
        logic       ol;
        logic       bo;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic [3:0] rv, input logic [3:0] rl, input logic ordy,
                              input logic [3:0] g, input logic [1:0] sel, input logic [3:0] rdy,
                              input logic stall, input logic ov, input logic ol, input logic bo);
        vec_t e;
        e.rv = rv; e.rl = rl; e.ordy = ordy; e.g = g; e.sel = sel; e.rdy = rdy;
        e.stall = stall; e.ov = ov; e.ol = ol; e.bo = bo;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b1;

        //  rv    rl    ordy grant sel  rdy  stl ov ol bo
        // round robin, single-beat packets: 0,1,2,3,0
        v(4'hF, 4'hF, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0);
        v(4'hF, 4'hF, 1, 4'h1, 2'd0, 4'h1, 0, 0, 0, 0);
        v(4'hF, 4'hF, 1, 4'h0, 2'd0, 4'h0, 0, 1, 1, 0);
        v(4'hF, 4'hF, 1, 4'h2, 2'd1, 4'h2, 0, 0, 0, 0);
        v(4'hF, 4'hF, 1, 4'h0, 2'd1, 4'h0, 0, 1, 1, 0);
        v(4'hF, 4'hF, 1, 4'h4, 2'd2, 4'h4, 0, 0, 0, 0);
        v(4'hF, 4'hF, 1, 4'h0, 2'd2, 4'h0, 0, 1, 1, 0);
        v(4'hF, 4'hF, 1, 4'h8, 2'd3, 4'h8, 0, 0, 0, 0);
        v(4'hF, 4'hF, 1, 4'h0, 2'd3, 4'h0, 0, 1, 1, 0);
        v(4'hF, 4'hF, 1, 4'h1, 2'd0, 4'h1, 0, 0, 0, 0);
        v(4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 1, 1, 0);
        v(4'h0, 4'h0, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0);
        // requester 1 alone moves ptr to 2
        v(4'h2, 4'h2, 1, 4'h0, 2'd0, 4'h0, 0, 0, 0, 0);
        v(4'h2, 4'h2, 1, 4'h2, 2'd1, 4'h2, 0, 0, 0, 0);
        // packet lock: 3 beats from 2 while 1 waits
        v(4'h6, 4'h0, 1, 4'h0, 2'd1, 4'h0, 0, 1, 1, 0);
        v(4'h6, 4'h0, 1, 4'h4, 2'd2, 4'h4, 0, 0, 0, 0);
        v(4'h6, 4'h0, 1, 4'h4, 2'd2, 4'h4, 0, 1, 0, 0);
        v(4'h6, 4'h4, 1, 4'h4, 2'd2, 4'h4, 0, 1, 0, 0);
        v(4'h2, 4'h0, 1, 4'h0, 2'd2, 4'h0, 0, 1, 1, 0);
        v(4'h2, 4'h2, 1, 4'h2, 2'd1, 4'h2, 0, 0, 0, 0);
        v(4'h0, 4'h0, 1, 4'h0, 2'd1, 4'h0, 0, 1, 1, 0);
        v(4'h0, 4'h0, 1, 4'h0, 2'd1, 4'h0, 0, 0, 0, 0);
        // backpressure for 3 cycles mid-packet
        v(4'h4, 4'h0, 1, 4'h0, 2'd1, 4'h0, 0, 0, 0, 0);
        v(4'h4, 4'h0, 1, 4'h4, 2'd2, 4'h4, 0, 0, 0, 0);
        v(4'h4, 4'h0, 0, 4'h4, 2'd2, 4'h0, 1, 1, 0, 0);
        v(4'h4, 4'h0, 0, 4'h4, 2'd2, 4'h0, 1, 1, 0, 0);
        v(4'h4, 4'h0, 0, 4'h4, 2'd2, 4'h0, 1, 1, 0, 0);
        v(4'h4, 4'h4, 1, 4'h4, 2'd2, 4'h4, 0, 1, 0, 0);
        v(4'h0, 4'h0, 1, 4'h0, 2'd2, 4'h0, 0, 1, 1, 0);
        v(4'h0, 4'h0, 1, 4'h0, 2'd2, 4'h0, 0, 0, 0, 0);
        // watchdog: requester 3 streams without last
        v(4'hA, 4'h0, 1, 4'h0, 2'd2, 4'h0, 0, 0, 0, 0);
        v(4'hA, 4'h0, 1, 4'h8, 2'd3, 4'h8, 0, 0, 0, 0);
        v(4'hA, 4'h0, 1, 4'h8, 2'd3, 4'h8, 0, 1, 0, 0);
        v(4'hA, 4'h0, 1, 4'h8, 2'd3, 4'h8, 0, 1, 0, 0);
        v(4'hA, 4'h0, 1, 4'h8, 2'd3, 4'h8, 0, 1, 0, 0);
        v(4'hA, 4'h0, 1, 4'h0, 2'd3, 4'h0, 0, 1, 0, 1);
        // valid gap from owner 1 while others request
        v(4'h2, 4'h0, 1, 4'h2, 2'd1, 4'h2, 0, 0, 0, 0);
        v(4'hD, 4'h0, 1, 4'h2, 2'd1, 4'h2, 0, 1, 0, 0);
        v(4'hD, 4'h0, 1, 4'h2, 2'd1, 4'h2, 0, 0, 0, 0);
        v(4'hF, 4'h2, 1, 4'h2, 2'd1, 4'h2, 0, 0, 0, 0);
        v(4'h0, 4'h0, 1, 4'h0, 2'd1, 4'h0, 0, 1, 1, 0);
        v(4'h0, 4'h0, 1, 4'h0, 2'd1, 4'h0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_grant", -1, 32'(grant), 32'h0);
        chk("rst_out_valid", -1, 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            req_valid = tbl[i].rv;
            req_last  = tbl[i].rl;
            out_ready = tbl[i].ordy;
            #1;
            chk("grant",         i, 32'(grant),         32'(tbl[i].g));
            chk("mux_sel",       i, 32'(mux_sel),       32'(tbl[i].sel));
            chk("req_ready",     i, 32'(req_ready),     32'(tbl[i].rdy));
            chk("mux_stall",     i, 32'(mux_stall),     32'(tbl[i].stall));
            chk("out_valid",     i, 32'(out_valid),     32'(tbl[i].ov));
            chk("out_last",      i, 32'(out_last),      32'(tbl[i].ol));
            chk("burst_overrun", i, 32'(burst_overrun), 32'(tbl[i].bo));
            @(negedge clk);
        end

        // Async reset mid-packet with a stalled valid beat; ptr is 2 here.
        req_valid = 4'h4;
        req_last  = 4'h0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("pre_rst_stall", 100, 32'(mux_stall), 32'h1);
        chk("pre_rst_ov",    100, 32'(out_valid), 32'h1);
        chk("pre_rst_grant", 100, 32'(grant),     32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 101, 32'(grant),         32'h0);
        chk("arst_sel",   101, 32'(mux_sel),       32'h0);
        chk("arst_ready", 101, 32'(req_ready),     32'h0);
        chk("arst_stall", 101, 32'(mux_stall),     32'h0);
        chk("arst_ov",    101, 32'(out_valid),     32'h0);
        chk("arst_ol",    101, 32'(out_last),      32'h0);
        chk("arst_bo",    101, 32'(burst_overrun), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'h5;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_grant", 102, 32'(grant),   32'h1);
        chk("post_rst_sel",   102, 32'(mux_sel), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
